// File: rtl/serial_byte_aligner.sv
// serial_byte_aligner
// Receive-side bit-to-byte aligner. Shifts in one serial bit per CLK
// (LSB first), locks onto a repeated COM symbol at a fixed byte phase,
// then delivers every aligned byte on data_out with a one-cycle valid_out.
// Optional build macro: SERIAL_ALIGNER_PASS_COM_EN
//   defined   -> boundary COM bytes in ACTIVE are delivered like data
//   undefined -> boundary COM bytes in ACTIVE are stripped (default)
module serial_byte_aligner #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC,
   parameter int         LOCK_COUNT = 4,
   parameter int         MISS_LIMIT = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      S_SEARCH    = 2'd0,
      S_CANDIDATE = 2'd1,
      S_ACTIVE    = 2'd2
   } state_t;

   localparam logic [3:0] C_LOCK = 4'(LOCK_COUNT);
   localparam logic [3:0] C_MISS = 4'(MISS_LIMIT);

`ifdef SERIAL_ALIGNER_PASS_COM_EN
   localparam logic C_PASS_COM = 1'b1;
`else
   localparam logic C_PASS_COM = 1'b0;
`endif

   state_t     r_state;
   logic [7:0] r_sr;
   logic [2:0] r_bit_cnt;
   logic [3:0] r_com_cnt;
   logic [3:0] r_miss_cnt;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_active;

   state_t     w_state_nxt;
   logic [7:0] w_sr_nxt;
   logic       w_match;
   logic       w_boundary;
   logic [2:0] w_bit_cnt_nxt;
   logic [3:0] w_com_cnt_nxt;
   logic [3:0] w_miss_cnt_nxt;
   logic [7:0] w_data_nxt;
   logic       w_valid_nxt;
   logic       w_active_nxt;

   // The byte window seen after this edge; COM is detected on it so the
   // decision lands on the same edge the 8th bit is shifted in.
   assign w_sr_nxt   = {data_in, r_sr[7:1]};
   assign w_match    = (w_sr_nxt == COM_SYMBOL);
   assign w_boundary = (r_bit_cnt == 3'd7);

   // State and datapath registers, cleared immediately by RESET.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_SEARCH;
         r_sr       <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_com_cnt  <= 4'd0;
         r_miss_cnt <= 4'd0;
         r_data     <= 8'h00;
         r_valid    <= 1'b0;
         r_active   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sr       <= w_sr_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_com_cnt  <= w_com_cnt_nxt;
         r_miss_cnt <= w_miss_cnt_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_active   <= w_active_nxt;
      end
   end

   // Next-state, counters and output byte selection.
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_com_cnt_nxt  = r_com_cnt;
      w_miss_cnt_nxt = r_miss_cnt;
      w_data_nxt     = r_data;
      w_valid_nxt    = 1'b0;

      case (r_state)
         S_SEARCH: begin
            // Any COM anywhere fixes the candidate byte phase.
            if (w_match) begin
               w_bit_cnt_nxt  = 3'd0;
               w_com_cnt_nxt  = 4'd1;
               w_miss_cnt_nxt = 4'd0;
               w_state_nxt    = (C_LOCK == 4'd1) ? S_ACTIVE : S_CANDIDATE;
            end
         end

         S_CANDIDATE: begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_boundary) begin
               if (w_match) begin
                  w_com_cnt_nxt = r_com_cnt + 4'd1;
                  if (r_com_cnt + 4'd1 == C_LOCK) begin
                     w_state_nxt    = S_ACTIVE;
                     w_miss_cnt_nxt = 4'd0;
                  end
               end else begin
                  w_state_nxt   = S_SEARCH;
                  w_com_cnt_nxt = 4'd0;
               end
            end
         end

         S_ACTIVE: begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_boundary) begin
               if (w_match) begin
                  w_miss_cnt_nxt = 4'd0;
               end
               if (!w_match || C_PASS_COM) begin
                  w_data_nxt  = w_sr_nxt;
                  w_valid_nxt = 1'b1;
               end
            end else if (w_match) begin
               // COM seen at the wrong phase: the stream has slipped.
               if (r_miss_cnt + 4'd1 == C_MISS) begin
                  w_state_nxt    = S_SEARCH;
                  w_com_cnt_nxt  = 4'd0;
                  w_miss_cnt_nxt = 4'd0;
               end else begin
                  w_miss_cnt_nxt = r_miss_cnt + 4'd1;
               end
            end
         end

         default: begin
            w_state_nxt = S_SEARCH;
         end
      endcase

      w_active_nxt = (w_state_nxt == S_ACTIVE);
   end

   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign active    = r_active;

endmodule

// File: tb/tb_serial_byte_aligner.sv
// Self-checking bench for serial_byte_aligner: directed byte streams,
// a phase-anchored reference model compared every cycle, and literal
// expectations per scenario. Honours SERIAL_ALIGNER_PASS_COM_EN.
module tb_serial_byte_aligner;

   localparam logic [7:0] COM  = 8'hBC;
   localparam int         LOCK = 4;
   localparam int         MISS = 2;
`ifdef SERIAL_ALIGNER_PASS_COM_EN
   localparam bit PASS = 1'b1;
`else
   localparam bit PASS = 1'b0;
`endif

   logic       CLK;
   logic       RESET;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   serial_byte_aligner #(
      .COM_SYMBOL(COM),
      .LOCK_COUNT(LOCK),
      .MISS_LIMIT(MISS)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .data_in  (data_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .active   (active)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: link state tracked as a mode plus the cycle at which
   // the byte phase was anchored; a boundary is every 8th bit after it.
   int         m_mode;      // 0 hunting, 1 confirming, 2 locked
   int         m_t, m_anchor, m_coms, m_misses;
   logic [7:0] m_win;
   bit         m_hit, m_on_b;
   logic [7:0] e_data;
   logic       e_valid, e_active;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_mode = 0; m_t = 0; m_anchor = 0; m_coms = 0; m_misses = 0;
         m_win = 8'h00; e_data = 8'h00; e_valid = 1'b0; e_active = 1'b0;
      end else begin
         m_t++;
         m_win   = {data_in, m_win[7:1]};
         m_hit   = (m_win == COM);
         m_on_b  = (m_mode != 0) && (((m_t - m_anchor) % 8) == 0);
         e_valid = 1'b0;
         if (m_mode == 0) begin
            if (m_hit) begin
               m_anchor = m_t; m_coms = 1; m_misses = 0;
               m_mode = (m_coms >= LOCK) ? 2 : 1;
            end
         end else if (m_mode == 1) begin
            if (m_on_b) begin
               if (m_hit) begin
                  m_coms++;
                  if (m_coms >= LOCK) begin m_mode = 2; m_misses = 0; end
               end else begin
                  m_mode = 0; m_coms = 0;
               end
            end
         end else begin
            if (m_on_b) begin
               if (m_hit) m_misses = 0;
               if (!m_hit || PASS) begin e_data = m_win; e_valid = 1'b1; end
            end else if (m_hit) begin
               m_misses++;
               if (m_misses >= MISS) begin m_mode = 0; m_coms = 0; m_misses = 0; end
            end
         end
         e_active = (m_mode == 2);
      end
   end

   // Per-cycle comparison against the model, plus capture of delivered bytes.
   logic [7:0] cap_d[$];
   int         cap_c[$];
   bit         watch_active = 1'b0;
   bit         dropped      = 1'b0;

   always @(negedge CLK) begin
      chk("model valid_out", valid_out, e_valid);
      chk("model active", active, e_active);
      chk("model data_out", data_out, e_data);
      if (valid_out) begin
         cap_d.push_back(data_out);
         cap_c.push_back(cyc);
      end
      if (watch_active && !active) dropped = 1'b1;
   end

   task automatic send_bit(input logic b);
      data_in = b;
      @(negedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic clear_cap();
      cap_d.delete();
      cap_c.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET   = 1'b0;
      data_in = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      chk("reset active", active, 0);
      chk("reset valid_out", valid_out, 0);
      chk("reset data_out", data_out, 8'h00);
      RESET = 1'b1;
      send_bit(1'b0);

      // Lock after three stray bits, then two data bytes.
      clear_cap();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      for (int k = 0; k < 3; k++) send_byte(COM);
      chk("lock early active", active, 0);
      send_byte(COM);
      chk("lock active rise", active, 1);
      chk("lock no valid on COM", valid_out, 0);
      send_byte(8'h5A);
      chk("lock valid 5A", valid_out, 1);
      chk("lock data 5A", data_out, 8'h5A);
      send_byte(8'hA5);
      chk("lock data A5", data_out, 8'hA5);
      chk("lock byte count", cap_d.size(), 2);
      if (cap_d.size() == 2) begin
         chk("lock first byte", cap_d[0], 8'h5A);
         chk("lock second byte", cap_d[1], 8'hA5);
         chk("lock spacing", cap_c[1] - cap_c[0], 8);
      end

      // COM handling in the locked state.
      clear_cap();
      send_byte(8'h00);
      send_byte(COM);
      send_byte(8'hFF);
      if (PASS) begin
         chk("com pass count", cap_d.size(), 3);
         if (cap_d.size() == 3) begin
            chk("com pass b0", cap_d[0], 8'h00);
            chk("com pass b1", cap_d[1], 8'hBC);
            chk("com pass b2", cap_d[2], 8'hFF);
         end
      end else begin
         chk("com strip count", cap_d.size(), 2);
         if (cap_d.size() == 2) begin
            chk("com strip b0", cap_d[0], 8'h00);
            chk("com strip b1", cap_d[1], 8'hFF);
            chk("com strip spacing", cap_c[1] - cap_c[0], 16);
         end
      end

      // Streaming 64 alternating bytes.
      clear_cap();
      watch_active = 1'b1;
      dropped      = 1'b0;
      for (int k = 0; k < 64; k++) send_byte((k % 2 == 0) ? 8'h00 : 8'hFF);
      watch_active = 1'b0;
      chk("stream count", cap_d.size(), 64);
      chk("stream active held", dropped, 0);
      for (int k = 0; k < cap_d.size() && k < 64; k++)
         chk("stream byte", cap_d[k], (k % 2 == 0) ? 8'h00 : 8'hFF);
      for (int k = 1; k < cap_c.size(); k++)
         chk("stream spacing", cap_c[k] - cap_c[k-1], 8);

      // One-bit slip: two off-phase COMs drop lock, four more relock.
      send_bit(1'b1);
      send_byte(COM);
      chk("slip first miss", active, 1);
      send_byte(COM);
      chk("slip drop", active, 0);
      for (int k = 0; k < 3; k++) send_byte(COM);
      chk("slip relock early", active, 0);
      send_byte(COM);
      chk("slip relock", active, 1);
      clear_cap();
      send_byte(COM);
      send_byte(8'h3C);
      chk("slip valid 3C", valid_out, 1);
      chk("slip data 3C", data_out, 8'h3C);
      chk("slip byte count", cap_d.size(), PASS ? 2 : 1);

      // Asynchronous reset in the middle of a byte while locked.
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      #1;
      RESET = 1'b0;
      #1;
      chk("async reset active", active, 0);
      chk("async reset valid_out", valid_out, 0);
      chk("async reset data_out", data_out, 8'h00);
      @(negedge CLK); @(negedge CLK);
      #1;
      RESET = 1'b1;
      clear_cap();
      send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h00);
      chk("post reset active", active, 0);
      chk("post reset no bytes", cap_d.size(), 0);

      // Failed lock attempt, then a good one.
      clear_cap();
      send_byte(COM); send_byte(COM); send_byte(8'h00);
      chk("fail lock active", active, 0);
      for (int k = 0; k < 3; k++) send_byte(COM);
      chk("fail lock still searching", active, 0);
      chk("fail lock no bytes", cap_d.size(), 0);
      send_byte(COM);
      chk("retry lock active", active, 1);
      send_byte(8'h3C);
      chk("retry data 3C", data_out, 8'h3C);
      chk("retry byte count", cap_d.size(), 1);

      send_bit(1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
